// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Shares one external combinational ALU between two requesters. Commands
//   arrive on valid/ready ports. One command is accepted at a time. Its operands
//   are registered onto the ALU inputs and held for a settle time, and then the
//   ALU result is captured. The result is returned on the owner's valid/ready
//   response port. A divide by zero never reaches the ALU result path: it
//   responds at once with all-ones data and the dz flag set.
//
// Parameters:
//   DW          operand width (ALU A/B)
//   RW          result width (ALU output)
//   OP_SETTLE   hold cycles before capture for non-divide ops (>=1)
//   DIV_SETTLE  hold cycles before capture for divide, op 3'b011 (>=1)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op       command port of requester N (N = 0, 1)
//   rspN_valid/ready/data/dz      response port of requester N
//   alu_a, alu_b, alu_op          registered operands to the shared ALU
//   alu_out                       result from the shared ALU
//   busy                          high whenever the FSM is not in IDLE
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins a tie and
//                          requester 1 can starve. When undefined, ties are
//                          resolved round-robin against the last grant.
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int DW         = 16,
  parameter int RW         = 32,
  parameter int OP_SETTLE  = 1,
  parameter int DIV_SETTLE = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [2:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [2:0]    req1_op,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [RW-1:0] rsp0_data,
  output logic          rsp0_dz,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [RW-1:0] rsp1_data,
  output logic          rsp1_dz,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [RW-1:0] alu_out,
  output logic          busy
);

  localparam logic [2:0] OP_DIV = 3'b011;

  // The counter only ever holds (settle - 1). Keep it at least one bit wide.
  localparam int MAX_SETTLE = (DIV_SETTLE > OP_SETTLE) ? DIV_SETTLE : OP_SETTLE;
  localparam int CW         = (MAX_SETTLE > 1) ? $clog2(MAX_SETTLE) : 1;
  localparam logic [CW-1:0] OP_LOAD  = CW'(OP_SETTLE - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic            r_last_grant;
  logic            r_owner;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_alu_a;
  logic [DW-1:0]   r_alu_b;
  logic [2:0]      r_alu_op;
  logic            r_rsp0_valid;
  logic            r_rsp1_valid;
  logic [RW-1:0]   r_rsp0_data;
  logic [RW-1:0]   r_rsp1_data;
  logic            r_rsp0_dz;
  logic            r_rsp1_dz;
  logic            r_busy;

  logic            w_grant;
  logic            w_accept;
  logic [DW-1:0]   w_sel_a;
  logic [DW-1:0]   w_sel_b;
  logic [2:0]      w_sel_op;
  logic            w_div_zero;
  logic            w_rsp_hs;

  // Grant selection from the two command valids.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_grant = 1'b0;
`else
      // On a tie, the requester that did not win last time goes next.
      w_grant = ~r_last_grant;
`endif
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  // A command is taken only in IDLE and never while reset is asserted.
  assign w_accept   = !rst && (r_state == ST_IDLE) && (req0_valid || req1_valid);

  // A grant always points at a valid requester, so each ready needs only the grant.
  assign req0_ready = w_accept && (w_grant == 1'b0);
  assign req1_ready = w_accept && (w_grant == 1'b1);

  // Operand mux toward the ALU registers.
  always_comb begin
    w_sel_a  = req0_a;
    w_sel_b  = req0_b;
    w_sel_op = req0_op;
    if (w_grant) begin
      w_sel_a  = req1_a;
      w_sel_b  = req1_b;
      w_sel_op = req1_op;
    end else begin
      w_sel_a  = req0_a;
      w_sel_b  = req0_b;
      w_sel_op = req0_op;
    end
  end

  assign w_div_zero = (w_sel_op == OP_DIV) && (w_sel_b == {DW{1'b0}});

  // A response handshake completes only on the owner's port while in RESP.
  assign w_rsp_hs = (r_state == ST_RESP) &&
                    (r_owner ? rsp1_ready : rsp0_ready);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_div_zero) begin
            w_next_state = ST_RESP;
          end else begin
            w_next_state = ST_EXEC;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (r_cnt == {CW{1'b0}}) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (w_rsp_hs) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: ALU operand registers, settle counter, ownership and responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= {CW{1'b0}};
      r_alu_a      <= {DW{1'b0}};
      r_alu_b      <= {DW{1'b0}};
      r_alu_op     <= 3'b000;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= {RW{1'b0}};
      r_rsp1_data  <= {RW{1'b0}};
      r_rsp0_dz    <= 1'b0;
      r_rsp1_dz    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
            r_alu_op     <= w_sel_op;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            if (w_div_zero) begin
              // Divide by zero: respond at once and ignore the ALU output.
              if (w_grant) begin
                r_rsp1_data  <= {RW{1'b1}};
                r_rsp1_dz    <= 1'b1;
                r_rsp1_valid <= 1'b1;
              end else begin
                r_rsp0_data  <= {RW{1'b1}};
                r_rsp0_dz    <= 1'b1;
                r_rsp0_valid <= 1'b1;
              end
            end else begin
              r_cnt <= (w_sel_op == OP_DIV) ? DIV_LOAD : OP_LOAD;
            end
          end
        end
        ST_EXEC: begin
          if (r_cnt == {CW{1'b0}}) begin
            // The operands have now been held for the full settle time.
            if (r_owner) begin
              r_rsp1_data  <= alu_out;
              r_rsp1_dz    <= 1'b0;
              r_rsp1_valid <= 1'b1;
            end else begin
              r_rsp0_data  <= alu_out;
              r_rsp0_dz    <= 1'b0;
              r_rsp0_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
          end
        end
        default: begin
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp1_data  = r_rsp1_data;
  assign rsp0_dz    = r_rsp0_dz;
  assign rsp1_dz    = r_rsp1_dz;
  assign busy       = r_busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed testbench for alu_share_arbiter with default parameters
// (OP_SETTLE=1, DIV_SETTLE=3). The bench models the shared ALU. All expected
// values are hand-computed constants. Inputs are driven and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_dz, rsp1_dz;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_out;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_dz(rsp0_dz),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_dz(rsp1_dz),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared combinational ALU model.
  always_comb begin
    alu_out = 32'h0000_0000;
    case (alu_op)
      3'b000: alu_out = {16'h0000, alu_a} + {16'h0000, alu_b};
      3'b001: alu_out = {16'h0000, alu_a} - {16'h0000, alu_b};
      3'b010: alu_out = {16'h0000, alu_a} * {16'h0000, alu_b};
      3'b011: alu_out = (alu_b == 16'h0000) ? 32'hFFFF_FFFF
                                            : {16'h0000, alu_a / alu_b};
      3'b100: alu_out = {16'h0000, alu_a & alu_b};
      3'b101: alu_out = {16'h0000, alu_a | alu_b};
      3'b110: alu_out = {16'h0000, ~alu_a};
      3'b111: alu_out = {16'h0000, ~alu_b};
      default: alu_out = 32'h0000_0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_rspv",   {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rst_data0",  rsp0_data, 32'd0);
    check("rst_data1",  rsp1_data, 32'd0);
    check("rst_dz",     {30'd0, rsp1_dz, rsp0_dz}, 32'd0);
    check("rst_alu",    {alu_op, 13'd0, alu_a | alu_b}, 32'd0);
    rst = 1'b0;
  endtask

  // Serve one command from requester 'who'. It is called at a falling edge in
  // IDLE with the command already driven. exp_lat counts the clock edges from
  // the accept edge until rsp_valid is visible. Response ready is held low for
  // 'hold' cycles before the handshake.
  task automatic serve(input int who, input logic [31:0] exp_d, input logic exp_dz,
                       input int exp_lat, input int hold, input bit drop);
    int lat;
    logic v, o_v;
    #1;
    check("grant_ready", {31'd0, (who == 1) ? req1_ready : req0_ready}, 32'd1);
    check("other_ready", {31'd0, (who == 1) ? req0_ready : req1_ready}, 32'd0);
    @(negedge clk);
    if (drop) begin
      if (who == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    v = (who == 1) ? rsp1_valid : rsp0_valid;
    while (!v && lat < 20) begin
      @(negedge clk);
      lat++;
      v = (who == 1) ? rsp1_valid : rsp0_valid;
    end
    check("rsp_latency", lat, exp_lat);
    check("rsp_data", (who == 1) ? rsp1_data : rsp0_data, exp_d);
    check("rsp_dz", {31'd0, (who == 1) ? rsp1_dz : rsp0_dz}, {31'd0, exp_dz});
    o_v = (who == 1) ? rsp0_valid : rsp1_valid;
    check("other_rsp_valid", {31'd0, o_v}, 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      #1;
      check("hold_valid", {31'd0, (who == 1) ? rsp1_valid : rsp0_valid}, 32'd1);
      check("hold_data", (who == 1) ? rsp1_data : rsp0_data, exp_d);
      check("hold_busy", {31'd0, busy}, 32'd1);
      check("hold_other_ready", {31'd0, (who == 1) ? req0_ready : req1_ready}, 32'd0);
    end
    if (who == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    check("rsp_cleared", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 16'd0; req0_b = 16'd0; req0_op = 3'b000;
    req1_a = 16'd0; req1_b = 16'd0; req1_op = 3'b000;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset values.
    do_reset();

    // Test 1: req0 subtraction 150 - 50.
    req0_valid = 1'b1; req0_a = 16'd150; req0_b = 16'd50; req0_op = 3'b001;
    serve(0, 32'd100, 1'b0, 1, 0, 1'b1);

    // Test 2: both requesters valid straight out of reset and held.
    req0_valid = 1'b1; req0_a = 16'd1;   req0_b = 16'd2; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 16'd160; req1_b = 16'd2; req1_op = 3'b010;
    do_reset();
`ifdef ALU_ARB_FIXED_PRIO_EN
    // Test 6: fixed priority always grants requester 0.
    serve(0, 32'd3, 1'b0, 1, 0, 1'b0);
    req0_a = 16'hF0F0; req0_b = 16'h0FF0; req0_op = 3'b100;
    serve(0, 32'h0000_00F0, 1'b0, 1, 0, 1'b0);
    req0_a = 16'h00F0; req0_b = 16'h0F00; req0_op = 3'b101;
    serve(0, 32'h0000_0FF0, 1'b0, 1, 0, 1'b0);
    req0_a = 16'h1234; req0_op = 3'b110;
    serve(0, 32'h0000_EDCB, 1'b0, 1, 0, 1'b1);
    #1;
    check("fixed_req1_now", {31'd0, req1_ready}, 32'd1);
    serve(1, 32'd320, 1'b0, 1, 0, 1'b1);
`else
    serve(0, 32'd3, 1'b0, 1, 0, 1'b0);
    req0_a = 16'hF0F0; req0_b = 16'h0FF0; req0_op = 3'b100;
    serve(1, 32'd320, 1'b0, 1, 0, 1'b0);
    req1_a = 16'd10; req1_b = 16'd3; req1_op = 3'b001;
    serve(0, 32'h0000_00F0, 1'b0, 1, 0, 1'b1);
    serve(1, 32'd7, 1'b0, 1, 0, 1'b1);
`endif

    // Test 3: req1 divide, then divide by zero.
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 16'd160; req1_b = 16'd2; req1_op = 3'b011;
    serve(1, 32'd80, 1'b0, 3, 0, 1'b1);
    req1_valid = 1'b1; req1_a = 16'd10; req1_b = 16'd0; req1_op = 3'b011;
    serve(1, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b1);
    check("alu_a_retained",  {16'd0, alu_a}, 32'd10);
    check("alu_b_retained",  {16'd0, alu_b}, 32'd0);
    check("alu_op_retained", {29'd0, alu_op}, 32'd3);

    // Test 4: a stalled response blocks the other requester.
    req0_valid = 1'b1; req0_a = 16'h0017; req0_b = 16'h001E; req0_op = 3'b100;
    req1_valid = 1'b1; req1_a = 16'd1; req1_b = 16'd1; req1_op = 3'b000;
    serve(0, 32'h0000_0016, 1'b0, 1, 5, 1'b1);
    #1;
    check("req1_ready_after_hs", {31'd0, req1_ready}, 32'd1);
    serve(1, 32'd2, 1'b0, 1, 0, 1'b1);

    // Test 5: reset asserted during EXEC of a multiply.
    req0_valid = 1'b1; req0_a = 16'd7; req0_b = 16'd6; req0_op = 3'b010;
    #1;
    check("t5_ready0", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    check("t5_in_exec", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("t5_ready_in_rst", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    check("t5_rspv", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_alu", {alu_op, 13'd0, alu_a | alu_b}, 32'd0);
    check("t5_data0", rsp0_data, 32'd0);
    check("t5_data1", rsp1_data, 32'd0);
    check("t5_dz", {30'd0, rsp1_dz, rsp0_dz}, 32'd0);
    @(negedge clk);
    check("t5_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    rst = 1'b0;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 16'd4; req0_b = 16'd5; req0_op = 3'b000;
    serve(0, 32'd9, 1'b0, 1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
